// File: rtl/sll_pkg.sv
// Shared opcodes, legality check and arbiter state
// for the singly-linked-list access arbiter.
package sll_pkg;

  localparam logic [2:0] OP_READ     = 3'd0;
  localparam logic [2:0] OP_INS_ADDR = 3'd1;
  localparam logic [2:0] OP_DEL_VAL  = 3'd2;
  localparam logic [2:0] OP_DEL_ADDR = 3'd3;
  localparam logic [2:0] OP_INS_IDX  = 3'd5;
  localparam logic [2:0] OP_DEL_IDX  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP
  } arb_state_e;

  function automatic logic op_is_legal(
    input logic [2:0] op
  );
    return op inside {OP_READ, OP_INS_ADDR,
                      OP_DEL_VAL, OP_DEL_ADDR,
                      OP_INS_IDX, OP_DEL_IDX};
  endfunction

endpackage

// File: rtl/sll_rr_pick.sv
// Combinational round-robin picker: first
// requester at or after ptr wins.
module sll_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  function automatic logic [IW-1:0] wrap(
    input logic [IW-1:0] p,
    input int            i
  );
    int s;
    s = int'(p) + i;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  // Scan farthest first so the nearest hit wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[wrap(ptr, i)]) begin
        gnt = '0;
        gnt[wrap(ptr, i)] = 1'b1;
        idx = wrap(ptr, i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sll_access_arbiter.sv
// Shares one linked-list engine among NUM_REQ
// requesters with watchdog and opcode screening.
module sll_access_arbiter
  import sll_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_NODE   = 8,
  parameter int TIMEOUT    = 64,
  parameter int ADDR_WIDTH = $clog2(MAX_NODE + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*3-1:0]          req_op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic [ADDR_WIDTH-1:0]         resp_next_addr,
  output logic                          resp_fault,
  output logic                          resp_timeout,
  output logic [2:0]                    ll_op,
  output logic [DATA_WIDTH-1:0]         ll_data_in,
  output logic [ADDR_WIDTH-1:0]         ll_addr_in,
  output logic                          ll_op_start,
  input  logic                          ll_op_done,
  input  logic [DATA_WIDTH-1:0]         ll_data_out,
  input  logic [ADDR_WIDTH-1:0]         ll_next_node_addr,
  input  logic                          ll_fault
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);

  arb_state_e            state_q, state_d;
  logic [IW-1:0]         rr_q, rr_d;
  logic [IW-1:0]         win_q, win_d;
  logic [2:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [TW-1:0]         wd_q, wd_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] rnext_q, rnext_d;
  logic                  rfault_q, rfault_d;
  logic                  rto_q, rto_d;

  logic [NUM_REQ-1:0]    pick_gnt;
  logic [IW-1:0]         pick_idx;
  logic                  pick_any;

  logic [2:0]            op_a   [NUM_REQ];
  logic [DATA_WIDTH-1:0] din_a  [NUM_REQ];
  logic [ADDR_WIDTH-1:0] addr_a [NUM_REQ];

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_unpack
    assign op_a[r]   = req_op[3*r +: 3];
    assign din_a[r]  = req_data[DATA_WIDTH*r +: DATA_WIDTH];
    assign addr_a[r] = req_addr[ADDR_WIDTH*r +: ADDR_WIDTH];
  end

  sll_rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    win_d       = win_q;
    op_d        = op_q;
    din_d       = din_q;
    addr_d      = addr_q;
    wd_d        = wd_q;
    rdata_d     = rdata_q;
    rnext_d     = rnext_q;
    rfault_d    = rfault_q;
    rto_d       = rto_q;
    req_ready   = '0;
    resp_valid  = '0;
    ll_op_start = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          req_ready = pick_gnt;
          win_d     = pick_idx;
          op_d      = op_a[pick_idx];
          din_d     = din_a[pick_idx];
          addr_d    = addr_a[pick_idx];
          wd_d      = '0;
          if (pick_idx == IW'(NUM_REQ - 1))
            rr_d = '0;
          else
            rr_d = pick_idx + 1'b1;
          if (op_is_legal(op_a[pick_idx])) begin
            state_d = S_ISSUE;
          end else begin
            state_d  = S_RESP;
            rdata_d  = '0;
            rnext_d  = '0;
            rfault_d = 1'b1;
            rto_d    = 1'b0;
          end
        end
      end
      S_ISSUE: begin
        ll_op_start = 1'b1;
        // A completion on the expiry cycle still counts.
        if (ll_op_done) begin
          state_d  = S_RESP;
          rdata_d  = ll_data_out;
          rnext_d  = ll_next_node_addr;
          rfault_d = ll_fault;
          rto_d    = 1'b0;
        end else if (wd_q == TW'(TIMEOUT - 1)) begin
          state_d  = S_RESP;
          rdata_d  = '0;
          rnext_d  = '0;
          rfault_d = 1'b1;
          rto_d    = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_RESP: begin
        resp_valid[win_q] = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_q     <= '0;
      win_q    <= '0;
      op_q     <= '0;
      din_q    <= '0;
      addr_q   <= '0;
      wd_q     <= '0;
      rdata_q  <= '0;
      rnext_q  <= '0;
      rfault_q <= 1'b0;
      rto_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      win_q    <= win_d;
      op_q     <= op_d;
      din_q    <= din_d;
      addr_q   <= addr_d;
      wd_q     <= wd_d;
      rdata_q  <= rdata_d;
      rnext_q  <= rnext_d;
      rfault_q <= rfault_d;
      rto_q    <= rto_d;
    end
  end

  assign ll_op          = op_q;
  assign ll_data_in     = din_q;
  assign ll_addr_in     = addr_q;
  assign resp_data      = rdata_q;
  assign resp_next_addr = rnext_q;
  assign resp_fault     = rfault_q;
  assign resp_timeout   = rto_q;

endmodule
